// File: rtl/ctrl_decode.sv
// MIPS instruction decoder: one-hot flags per instruction, plus a reserved-instruction detector when CTRL_RI_DETECT_EN is defined.
// Latency: flags and ri are combinational from I with no delay; ri_seen is registered on clk.
// Backpressure: none; the outputs follow I at all times.
module ctrl_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] I,
   output logic lb, lbu, lh, lhu, lw, sb, sh, sw,
   output logic R,
   output logic add, addu, sub, subu, slt, sltu, sll, srl, sra, sllv, srlv, srav,
   output logic and_, or_, xor_, nor_,
   output logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
   output logic addi, addiu, andi, ori, xori, lui, slti, sltiu,
   output logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
   output logic eret, mfc0, mtc0,
   output logic ri,
   output logic ri_seen
);

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [5:0] funct;

   assign op    = I[31:26];
   assign rs    = I[25:21];
   assign rt    = I[20:16];
   assign funct = I[5:0];

   // Instruction flag decode; SPECIAL uses funct only, REGIMM uses rt, COP0 uses rs.
   always_comb begin
      lb = 1'b0; lbu = 1'b0; lh = 1'b0; lhu = 1'b0; lw = 1'b0; sb = 1'b0; sh = 1'b0; sw = 1'b0;
      add = 1'b0; addu = 1'b0; sub = 1'b0; subu = 1'b0; slt = 1'b0; sltu = 1'b0;
      sll = 1'b0; srl = 1'b0; sra = 1'b0; sllv = 1'b0; srlv = 1'b0; srav = 1'b0;
      and_ = 1'b0; or_ = 1'b0; xor_ = 1'b0; nor_ = 1'b0;
      mult = 1'b0; multu = 1'b0; div = 1'b0; divu = 1'b0;
      mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      addi = 1'b0; addiu = 1'b0; andi = 1'b0; ori = 1'b0; xori = 1'b0; lui = 1'b0;
      slti = 1'b0; sltiu = 1'b0;
      beq = 1'b0; bne = 1'b0; blez = 1'b0; bgtz = 1'b0; bltz = 1'b0; bgez = 1'b0;
      j = 1'b0; jal = 1'b0; jalr = 1'b0; jr = 1'b0;
      eret = 1'b0; mfc0 = 1'b0; mtc0 = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h00: sll   = 1'b1;
               6'h02: srl   = 1'b1;
               6'h03: sra   = 1'b1;
               6'h04: sllv  = 1'b1;
               6'h06: srlv  = 1'b1;
               6'h07: srav  = 1'b1;
               6'h08: jr    = 1'b1;
               6'h09: jalr  = 1'b1;
               6'h10: mfhi  = 1'b1;
               6'h11: mthi  = 1'b1;
               6'h12: mflo  = 1'b1;
               6'h13: mtlo  = 1'b1;
               6'h18: mult  = 1'b1;
               6'h19: multu = 1'b1;
               6'h1A: div   = 1'b1;
               6'h1B: divu  = 1'b1;
               6'h20: add   = 1'b1;
               6'h21: addu  = 1'b1;
               6'h22: sub   = 1'b1;
               6'h23: subu  = 1'b1;
               6'h24: and_  = 1'b1;
               6'h25: or_   = 1'b1;
               6'h26: xor_  = 1'b1;
               6'h27: nor_  = 1'b1;
               6'h2A: slt   = 1'b1;
               6'h2B: sltu  = 1'b1;
               default: ;
            endcase
         end
         6'h01: begin
            if (rt == 5'd0)      bltz = 1'b1;
            else if (rt == 5'd1) bgez = 1'b1;
         end
         6'h02: j     = 1'b1;
         6'h03: jal   = 1'b1;
         6'h04: beq   = 1'b1;
         6'h05: bne   = 1'b1;
         6'h06: blez  = 1'b1;
         6'h07: bgtz  = 1'b1;
         6'h08: addi  = 1'b1;
         6'h09: addiu = 1'b1;
         6'h0A: slti  = 1'b1;
         6'h0B: sltiu = 1'b1;
         6'h0C: andi  = 1'b1;
         6'h0D: ori   = 1'b1;
         6'h0E: xori  = 1'b1;
         6'h0F: lui   = 1'b1;
         6'h10: begin
            // eret is matched on the full word; its rs field (10000) never collides with mfc0/mtc0
            if (I == 32'h4200_0018) eret = 1'b1;
            else if (rs == 5'd0)    mfc0 = 1'b1;
            else if (rs == 5'd4)    mtc0 = 1'b1;
         end
         6'h20: lb  = 1'b1;
         6'h21: lh  = 1'b1;
         6'h23: lw  = 1'b1;
         6'h24: lbu = 1'b1;
         6'h25: lhu = 1'b1;
         6'h28: sb  = 1'b1;
         6'h29: sh  = 1'b1;
         6'h2B: sw  = 1'b1;
         default: ;
      endcase
   end

   // R marks SPECIAL instructions that write rd; jr and the HI/LO writers are excluded.
   always_comb begin
      R = sll | srl | sra | sllv | srlv | srav | jalr | mfhi | mflo |
          add | addu | sub | subu | and_ | or_ | xor_ | nor_ | slt | sltu;
   end

`ifdef CTRL_RI_DETECT_EN
   logic any_flag;

   // Reserved instruction means no flag fired; R never fires alone, so it is left out.
   always_comb begin
      any_flag = lb | lbu | lh | lhu | lw | sb | sh | sw |
                 add | addu | sub | subu | slt | sltu | sll | srl | sra | sllv | srlv | srav |
                 and_ | or_ | xor_ | nor_ |
                 mult | multu | div | divu | mfhi | mflo | mthi | mtlo |
                 addi | addiu | andi | ori | xori | lui | slti | sltiu |
                 beq | bne | blez | bgtz | bltz | bgez | j | jal | jalr | jr |
                 eret | mfc0 | mtc0;
      ri = ~any_flag;
   end

   // Sticky status: set by any reserved instruction, cleared only by reset (reset wins).
   always_ff @(posedge clk) begin
      if (reset) ri_seen <= 1'b0;
      else       ri_seen <= ri_seen | ri;
   end
`else
   // Detector not built: clock and reset have no load in this build.
   logic unused_clk_reset;
   assign unused_clk_reset = clk & reset;
   assign ri      = 1'b0;
   assign ri_seen = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_decode.sv
module tb_ctrl_decode;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] I = 32'h0;
   logic lb, lbu, lh, lhu, lw, sb, sh, sw, R;
   logic add, addu, sub, subu, slt, sltu, sll, srl, sra, sllv, srlv, srav;
   logic and_, or_, xor_, nor_;
   logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
   logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
   logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr;
   logic eret, mfc0, mtc0, ri, ri_seen;

   int checks = 0;
   int errors = 0;

`ifdef CTRL_RI_DETECT_EN
   localparam bit RI_EN = 1'b1;
`else
   localparam bit RI_EN = 1'b0;
`endif

   typedef struct packed {
      logic lb, lbu, lh, lhu, lw, sb, sh, sw;
      logic add, addu, sub, subu, slt, sltu, sll, srl, sra, sllv, srlv, srav;
      logic and_, or_, xor_, nor_;
      logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
      logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
      logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr;
      logic eret, mfc0, mtc0;
   } flags_t;

   flags_t obs;
   assign obs = {lb, lbu, lh, lhu, lw, sb, sh, sw,
                 add, addu, sub, subu, slt, sltu, sll, srl, sra, sllv, srlv, srav,
                 and_, or_, xor_, nor_,
                 mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
                 addi, addiu, andi, ori, xori, lui, slti, sltiu,
                 beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                 eret, mfc0, mtc0};

   ctrl_decode dut (
      .clk(clk), .reset(reset), .I(I),
      .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw), .sb(sb), .sh(sh), .sw(sw),
      .R(R),
      .add(add), .addu(addu), .sub(sub), .subu(subu), .slt(slt), .sltu(sltu),
      .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
      .and_(and_), .or_(or_), .xor_(xor_), .nor_(nor_),
      .mult(mult), .multu(multu), .div(div), .divu(divu),
      .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
      .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori), .lui(lui),
      .slti(slti), .sltiu(sltiu),
      .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
      .j(j), .jal(jal), .jalr(jalr), .jr(jr),
      .eret(eret), .mfc0(mfc0), .mtc0(mtc0),
      .ri(ri), .ri_seen(ri_seen)
   );

   always #5 clk = ~clk;

   // Opcodes (other fields zero) that name an instruction.
   function automatic bit op_valid(input logic [5:0] o);
      case (o)
         6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
         6'h10, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit fn_valid(input logic [5:0] f);
      case (f)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
         6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit fn_writes_rd(input logic [5:0] f);
      case (f)
         6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: return 1'b0;
         default: return fn_valid(f);
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      I = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (ri_seen !== 1'b0 || sll !== 1'b1 || R !== 1'b1) begin
         errors++;
         $display("FAIL reset ri_seen=%b sll=%b R=%b expected ri_seen=0 sll=1 R=1", ri_seen, sll, R);
      end
      reset = 1'b0;
   endtask

   task automatic test_decode();
      logic [31:0] vi[14];
      flags_t      ve[14];
      bit          vr[14];
      bit          eri;
      for (int k = 0; k < 14; k++) begin
         ve[k] = '0;
         vr[k] = 1'b0;
      end
      vi[0]  = 32'h0000_0000; ve[0].sll   = 1'b1; vr[0]  = 1'b1;
      vi[1]  = 32'h8C00_0000; ve[1].lw    = 1'b1;
      vi[2]  = 32'h0C00_0000; ve[2].jal   = 1'b1;
      vi[3]  = 32'h0000_0009; ve[3].jalr  = 1'b1; vr[3]  = 1'b1;
      vi[4]  = 32'h0000_0008; ve[4].jr    = 1'b1;
      vi[5]  = 32'h0000_0018; ve[5].mult  = 1'b1;
      vi[6]  = 32'h0000_0010; ve[6].mfhi  = 1'b1; vr[6]  = 1'b1;
      vi[7]  = 32'h3C00_0000; ve[7].lui   = 1'b1;
      vi[8]  = 32'h0000_0027; ve[8].nor_  = 1'b1; vr[8]  = 1'b1;
      vi[9]  = 32'hAC00_0000; ve[9].sw    = 1'b1;
      vi[10] = 32'h03E0_F820; ve[10].add  = 1'b1; vr[10] = 1'b1;
      vi[11] = 32'h0000_0001;
      vi[12] = 32'h2000_0000; ve[12].addi = 1'b1;
      vi[13] = 32'h9400_0000; ve[13].lhu  = 1'b1;
      for (int k = 0; k < 14; k++) begin
         I = vi[k];
         #1;
         eri = RI_EN && (ve[k] == '0);
         checks++;
         if (obs !== ve[k] || R !== vr[k] || ri !== eri) begin
            errors++;
            $display("FAIL decode I=%h flags=%h R=%b ri=%b expected flags=%h R=%b ri=%b",
                     I, obs, R, ri, ve[k], vr[k], eri);
         end
      end
   endtask

   task automatic test_regimm_cop0();
      logic [31:0] vi[8];
      flags_t      ve[8];
      bit          eri;
      for (int k = 0; k < 8; k++) ve[k] = '0;
      vi[0] = 32'h4200_0018; ve[0].eret = 1'b1;
      vi[1] = 32'h4000_0000; ve[1].mfc0 = 1'b1;
      vi[2] = 32'h4080_0000; ve[2].mtc0 = 1'b1;
      vi[3] = 32'h4200_0019;
      vi[4] = 32'h0401_0000; ve[4].bgez = 1'b1;
      vi[5] = 32'h0400_0000; ve[5].bltz = 1'b1;
      vi[6] = 32'h0402_0000;
      vi[7] = 32'h4040_0000;
      for (int k = 0; k < 8; k++) begin
         I = vi[k];
         #1;
         eri = RI_EN && (ve[k] == '0);
         checks++;
         if (obs !== ve[k] || R !== 1'b0 || ri !== eri) begin
            errors++;
            $display("FAIL regimm_cop0 I=%h flags=%h R=%b ri=%b expected flags=%h R=0 ri=%b",
                     I, obs, R, ri, ve[k], eri);
         end
      end
   endtask

   task automatic test_sweep();
      logic [5:0] v;
      bit         ok;
      bit         er;
      for (int k = 0; k < 64; k++) begin
         v = k[5:0];
         I = {v, 26'h0};
         #1;
         ok = op_valid(v);
         er = (v == 6'h00);
         checks++;
         if ($countones(obs) !== int'(ok) || ri !== (RI_EN && !ok) || R !== er) begin
            errors++;
            $display("FAIL op_sweep I=%h nflags=%0d ri=%b R=%b expected nflags=%0d ri=%b R=%b",
                     I, $countones(obs), ri, R, ok, RI_EN && !ok, er);
         end
      end
      for (int k = 0; k < 64; k++) begin
         v = k[5:0];
         I = {6'h00, 20'hABCDE, v};
         #1;
         ok = fn_valid(v);
         er = fn_writes_rd(v);
         checks++;
         if ($countones(obs) !== int'(ok) || ri !== (RI_EN && !ok) || R !== er) begin
            errors++;
            $display("FAIL funct_sweep I=%h nflags=%0d ri=%b R=%b expected nflags=%0d ri=%b R=%b",
                     I, $countones(obs), ri, R, ok, RI_EN && !ok, er);
         end
      end
   endtask

   task automatic test_sticky();
      reset = 1'b1;
      I = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      I = 32'hFC00_0000;
      #1;
      checks++;
      if (obs !== '0 || ri !== RI_EN || ri_seen !== 1'b0) begin
         errors++;
         $display("FAIL sticky_pre flags=%h ri=%b ri_seen=%b expected flags=0 ri=%b ri_seen=0",
                  obs, ri, ri_seen, RI_EN);
      end
      @(posedge clk); #1;
      checks++;
      if (ri_seen !== RI_EN) begin
         errors++;
         $display("FAIL sticky_set ri_seen=%b expected %b", ri_seen, RI_EN);
      end
      I = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (ri_seen !== RI_EN || ri !== 1'b0) begin
         errors++;
         $display("FAIL sticky_hold ri_seen=%b ri=%b expected ri_seen=%b ri=0", ri_seen, ri, RI_EN);
      end
      reset = 1'b1;
      I = 32'h8C00_0000;
      #1;
      checks++;
      if (lw !== 1'b1 || $countones(obs) !== 1) begin
         errors++;
         $display("FAIL decode_in_reset lw=%b nflags=%0d expected lw=1 nflags=1", lw, $countones(obs));
      end
      I = 32'hFC00_0000;
      @(posedge clk); #1;
      checks++;
      if (ri_seen !== 1'b0) begin
         errors++;
         $display("FAIL sticky_reset_priority ri_seen=%b expected 0", ri_seen);
      end
      reset = 1'b0;
      I = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (ri_seen !== 1'b0) begin
         errors++;
         $display("FAIL sticky_after_reset ri_seen=%b expected 0", ri_seen);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_regimm_cop0();
      test_sweep();
      test_sticky();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_decode.md
# ctrl_decode

Combinational MIPS instruction decoder for the five-stage pipeline. Each pipeline register (ID/EX, EX/MEM, MEM/WB) instantiates one copy on its latched instruction word and derives its local control (RegDst, RegWrite, forwarding selects) from the one-hot flags. An optional reserved-instruction detector with a sticky status bit is the only clocked logic.

## Interface
Parameters: none.
- clk  input  1  clock; used only by the sticky reserved-instruction flag.
- reset  input  1  synchronous, active-high; clears the sticky flag.
- I  input  32  instruction word.
- lb, lbu, lh, lhu, lw, sb, sh, sw  output  1 each  load/store flags.
- R  output  1  R-type that writes rd.
- add, addu, sub, subu, slt, sltu, sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_  output  1 each  ALU R-type flags.
- mult, multu, div, divu, mfhi, mflo, mthi, mtlo  output  1 each  HI/LO flags.
- addi, addiu, andi, ori, xori, lui, slti, sltiu  output  1 each  immediate ALU flags.
- beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr  output  1 each  control-flow flags.
- eret, mfc0, mtc0  output  1 each  CP0 flags.
- ri  output  1  reserved instruction (combinational).
- ri_seen  output  1  sticky reserved-instruction status.

## Operation
- Fields: op=I[31:26], rs=I[25:21], rt=I[20:16], funct=I[5:0].
- op=0x00 decodes by funct only; rs, rt, rd and shamt are ignored: sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08, jalr 09, mfhi 10, mthi 11, mflo 12, mtlo 13, mult 18, multu 19, div 1A, divu 1B, add 20, addu 21, sub 22, subu 23, and_ 24, or_ 25, xor_ 26, nor_ 27, slt 2A, sltu 2B.
- R = op==0 AND funct is a listed code AND funct ∉ {jr, mult, multu, div, divu, mthi, mtlo}.
- op=0x01 (REGIMM): bltz when rt=0, bgez when rt=1; other rt values decode as reserved.
- Opcodes: j 02, jal 03, beq 04, bne 05, blez 06, bgtz 07, addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F, lb 20, lh 21, lw 23, lbu 24, lhu 25, sb 28, sh 29, sw 2B.
- op=0x10 (COP0): mfc0 when rs=00000, mtc0 when rs=00100. eret only when I==0x42000018 exactly.
- At most one instruction flag is 1 at a time; R may be 1 together with its instruction flag.
- I=0x00000000 (nop) decodes as sll with R=1.
- ri=1 when no instruction flag is 1.

## Timing
- All decode flags and ri are purely combinational from I, with zero-cycle latency.
- ri_seen: on a rising edge of clk, reset=1 forces 0; otherwise ri_seen <= ri_seen | ri. Reset takes priority when it coincides with ri=1.
- ri_seen holds its value until the next reset. Reset value is 0.
- Decode outputs have no reset value; they follow I at all times, including while reset is asserted.

## Configuration
- CTRL_RI_DETECT_EN defined: ri and ri_seen behave as specified above.
- CTRL_RI_DETECT_EN undefined: ri and ri_seen are tied to 0 and the flip-flop is not built. Decode flags are identical in both builds.

## Test plan
- I=0x00000000 -> sll=1, R=1; all other flags 0; ri=0.
- I=0x8C000000 -> lw=1, R=0. I=0x0C000000 -> jal=1. I=0x00000009 -> jalr=1, R=1. I=0x00000008 -> jr=1, R=0.
- I=0x42000018 -> eret=1. I=0x40000000 -> mfc0=1. I=0x40800000 -> mtc0=1. I=0x42000019 -> ri=1.
- I=0x04010000 -> bgez=1. I=0x04000000 -> bltz=1. I=0x04020000 -> ri=1.
- I=0xFC000000 (undefined opcode) -> all flags 0, ri=1; ri_seen=1 after the next edge; holds when I returns to 0; reset -> ri_seen=0 on the following edge.
- Sweep all 64 opcodes and all 64 functs -> exactly one flag set (R excepted) or ri=1, never both.
